// File: rtl/if_fetch.sv
// RV32I instruction-fetch stage: assembles each 32-bit instruction from four
// little-endian byte reads and presents it to the IF/ID register until consumed.
module if_fetch #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [7:0]        mem_data_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [31:0]       if_inst_o,
  output logic              if_valid_o
);

  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    F3   = 3'd3,
    HOLD = 3'd4
  } state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [7:0]        byte_buf_reg [3];
  logic [ADDR_W-1:0] if_pc_reg;
  logic [31:0]       if_inst_reg;
  logic              if_valid_reg;

  logic              fetching;
  logic [1:0]        byte_idx;
  logic [2:0]        lane_we;

  // In HOLD the low state bits are 00, so the address idles at pc.
  assign fetching = (state_reg != HOLD);
  assign byte_idx = state_reg[1:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_lane
      assign lane_we[gi] = fetching && mem_ack_i && (byte_idx == 2'(gi));
    end
  endgenerate

  // Request is gated by rst directly so it drops in the same cycle reset is applied.
  assign mem_req_o  = fetching && !rst;
  assign mem_addr_o = pc_reg + ADDR_W'(byte_idx);

  assign if_pc_o    = if_pc_reg;
  assign if_inst_o  = if_inst_reg;
  assign if_valid_o = if_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= F0;
      pc_reg       <= RESET_PC;
      for (int i = 0; i < 3; i++) byte_buf_reg[i] <= '0;
      if_pc_reg    <= '0;
      if_inst_reg  <= '0;
      if_valid_reg <= 1'b0;
    end else if (branch_i) begin
      // Redirect discards any partial fetch, same-cycle ack, or held instruction.
      state_reg    <= F0;
      pc_reg       <= branch_target_i & ~ADDR_W'(3);
      for (int i = 0; i < 3; i++) byte_buf_reg[i] <= '0;
      if_pc_reg    <= '0;
      if_inst_reg  <= '0;
      if_valid_reg <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (lane_we[i]) byte_buf_reg[i] <= mem_data_i;
      end
      case (state_reg)
        F0: if (mem_ack_i) state_reg <= F1;
        F1: if (mem_ack_i) state_reg <= F2;
        F2: if (mem_ack_i) state_reg <= F3;
        F3: begin
          if (mem_ack_i) begin
            state_reg    <= HOLD;
            if_inst_reg  <= {mem_data_i, byte_buf_reg[2], byte_buf_reg[1], byte_buf_reg[0]};
            if_pc_reg    <= pc_reg;
            if_valid_reg <= 1'b1;
            pc_reg       <= pc_reg + ADDR_W'(4);
          end
        end
        HOLD: begin
          if (!stall_i) begin
            state_reg    <= F0;
            if_pc_reg    <= '0;
            if_inst_reg  <= '0;
            if_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= F0;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a byte memory answers requests, a scoreboard
// queue holds expected (pc, inst) pairs and a monitor checks each presentation.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_i;
  logic [31:0] branch_target_i;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [7:0]  mem_data_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mem [512];
  int         errors = 0;
  int         checks = 0;
  logic       prev_valid = 1'b0;

  if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_i        (branch_i),
    .branch_target_i (branch_target_i),
    .mem_req_o       (mem_req_o),
    .mem_addr_o      (mem_addr_o),
    .mem_ack_i       (mem_ack_i),
    .mem_data_i      (mem_data_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic put_word(input int addr, input logic [31:0] w);
    for (int b = 0; b < 4; b++) mem[(addr + b) % 512] = w[8*b +: 8];
  endtask

  // Drive controls at the falling edge; the memory answers the settled address.
  task automatic apply(input logic r, input logic s, input logic br,
                       input logic [31:0] tgt, input logic ack);
    rst             = r;
    stall_i         = s;
    branch_i        = br;
    branch_target_i = tgt;
    #1;
    mem_ack_i  = ack & mem_req_o;
    mem_data_i = mem[mem_addr_o[8:0]];
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch_no_wait(input logic [31:0] base);
    for (int k = 0; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk($sformatf("req_%h_b%0d", base, k), {31'b0, mem_req_o}, 32'd1);
      chk($sformatf("addr_%h_b%0d", base, k), mem_addr_o, base + k);
      step();
    end
  endtask

  // Monitor: one line per presented instruction, zero bubble otherwise.
  always @(negedge clk) begin
    if (if_valid_o === 1'b1 && prev_valid !== 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pc=%h inst=%h expected none", if_pc_o, if_inst_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("txn pc=%h inst=%h (expect pc=%h inst=%h)", if_pc_o, if_inst_o, e.pc, e.inst);
        chk("mon_pc", if_pc_o, e.pc);
        chk("mon_inst", if_inst_o, e.inst);
      end
    end else if (if_valid_o !== 1'b1) begin
      chk("bubble_pc", if_pc_o, 32'h0);
      chk("bubble_inst", if_inst_o, 32'h0);
    end
    prev_valid = if_valid_o;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    put_word(32'h000, 32'h00A0_0513);
    put_word(32'h004, 32'h0010_0593);
    put_word(32'h008, 32'h00B5_0633);
    put_word(32'h00C, 32'h40C6_06B3);
    put_word(32'h100, 32'h0000_006F);
    put_word(32'h1FC, 32'h0001_0113);

    rst = 1'b1; stall_i = 1'b0; branch_i = 1'b0; branch_target_i = '0;
    mem_ack_i = 1'b0; mem_data_i = '0;
    @(negedge clk);
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("reset_req", {31'b0, mem_req_o}, 32'd0);
    chk("reset_valid", {31'b0, if_valid_o}, 32'd0);
    step();

    // Back-to-back acks.
    exp_q.push_back('{pc: 32'h0, inst: 32'h00A0_0513});
    fetch_no_wait(32'h0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("hold_req", {31'b0, mem_req_o}, 32'd0);
    chk("hold_valid", {31'b0, if_valid_o}, 32'd1);
    step();

    // Ack withheld three cycles on byte 2.
    exp_q.push_back('{pc: 32'h4, inst: 32'h0010_0593});
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("wait_addr_lo", mem_addr_o, 32'h4 + k);
      step();
    end
    for (int w = 0; w < 3; w++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      chk("wait_addr_stable", mem_addr_o, 32'h6);
      chk("wait_req", {31'b0, mem_req_o}, 32'd1);
      step();
    end
    for (int k = 2; k < 4; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("wait_addr_hi", mem_addr_o, 32'h4 + k);
      step();
    end

    // Stall in HOLD for four cycles.
    for (int s = 0; s < 4; s++) begin
      apply(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("stall_valid", {31'b0, if_valid_o}, 32'd1);
      chk("stall_req", {31'b0, mem_req_o}, 32'd0);
      chk("stall_pc", if_pc_o, 32'h4);
      chk("stall_inst", if_inst_o, 32'h0010_0593);
      step();
    end
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("unstall_valid", {31'b0, if_valid_o}, 32'd1);
    step();

    // Branch during F2 with a simultaneous ack.
    for (int k = 0; k < 2; k++) begin
      apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("pre_br_addr", mem_addr_o, 32'h8 + k);
      step();
    end
    apply(1'b0, 1'b0, 1'b1, 32'h0000_0102, 1'b1);
    chk("br_f2_addr", mem_addr_o, 32'hA);
    step();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("br_target_addr", mem_addr_o, 32'h100);
    chk("br_valid", {31'b0, if_valid_o}, 32'd0);
    exp_q.push_back('{pc: 32'h100, inst: 32'h0000_006F});
    fetch_no_wait(32'h100);

    // Branch with stall while holding: held instruction dropped.
    apply(1'b0, 1'b1, 1'b1, 32'h0000_0008, 1'b0);
    chk("brstall_valid_before", {31'b0, if_valid_o}, 32'd1);
    step();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("brstall_valid_after", {31'b0, if_valid_o}, 32'd0);
    chk("brstall_addr", mem_addr_o, 32'h8);
    exp_q.push_back('{pc: 32'h8, inst: 32'h00B5_0633});
    fetch_no_wait(32'h8);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Reset during F1 discards the partial fetch.
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("pre_rst_addr", mem_addr_o, 32'hC);
    step();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("rst_f1_req", {31'b0, mem_req_o}, 32'd0);
    step();
    apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("post_rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("post_rst_addr", mem_addr_o, 32'h0);
    chk("post_rst_valid", {31'b0, if_valid_o}, 32'd0);
    step();
    exp_q.push_back('{pc: 32'h0, inst: 32'h00A0_0513});
    fetch_no_wait(32'h0);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();

    // Unaligned target near the top of the address space; address wraps to 0.
    apply(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0);
    step();
    exp_q.push_back('{pc: 32'hFFFF_FFFC, inst: 32'h0001_0113});
    fetch_no_wait(32'hFFFF_FFFC);
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("wrap_addr", mem_addr_o, 32'h0);
    step();
    step();

    chk("pending_expected", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
